sr_latch_bank: RTL and testbench



---
 rtl/sr_latch_bank_if.sv | 29 ++
 rtl/sr_latch_bank.sv | 116 +++++++++++
 tb/tb_sr_latch_bank.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/sr_latch_bank_if.sv
// ------------------------------------------------------------------------
// sr_latch_bank_if : request inputs and latched-state outputs of the bank
// Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

interface sr_latch_bank_if #(
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0] s_n;
  logic [NUM_CH-1:0] r_n;
  logic              force_clr;
  logic [NUM_CH-1:0] q;
  logic [NUM_CH-1:0] q_bar;
  logic [NUM_CH-1:0] set_pulse;
  logic [NUM_CH-1:0] clr_pulse;

  modport master (
    output s_n, r_n, force_clr,
    input  q, q_bar, set_pulse, clr_pulse
  );

  modport slave (
    input  s_n, r_n, force_clr,
    output q, q_bar, set_pulse, clr_pulse
  );
endinterface

`default_nettype wire

// File: rtl/sr_latch_bank.sv
// ------------------------------------------------------------------------
// sr_latch_bank : debounced reset-dominant SR channels with set/clear strobes
// Optional SR_LATCH_BANK_SYNC_EN adds 2-flop input synchronisers. Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module sr_latch_bank #(
  parameter int NUM_CH          = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  wire              clk,
  input  wire              rst_n,
  sr_latch_bank_if.slave   bus
);

  localparam int                 C_CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam int                 C_NB       = 2 * NUM_CH;

  logic [NUM_CH-1:0] w_s_in;
  logic [NUM_CH-1:0] w_r_in;

`ifdef SR_LATCH_BANK_SYNC_EN
  logic [NUM_CH-1:0] r_s_meta;
  logic [NUM_CH-1:0] r_s_sync;
  logic [NUM_CH-1:0] r_r_meta;
  logic [NUM_CH-1:0] r_r_sync;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s_meta <= '1;
      r_s_sync <= '1;
      r_r_meta <= '1;
      r_r_sync <= '1;
    end else begin
      r_s_meta <= bus.s_n;
      r_s_sync <= r_s_meta;
      r_r_meta <= bus.r_n;
      r_r_sync <= r_r_meta;
    end
  end

  assign w_s_in = r_s_sync;
  assign w_r_in = r_r_sync;
`else
  assign w_s_in = bus.s_n;
  assign w_r_in = bus.r_n;
`endif

  // Set inputs occupy the low half, reset inputs the high half.
  logic [C_NB-1:0] w_raw;
  logic [C_NB-1:0] w_filt;
  logic [NUM_CH-1:0] w_s_filt;
  logic [NUM_CH-1:0] w_r_filt;

  assign w_raw    = {w_r_in, w_s_in};
  assign w_s_filt = w_filt[NUM_CH-1:0];
  assign w_r_filt = w_filt[C_NB-1:NUM_CH];

  for (genvar j = 0; j < C_NB; j++) begin : g_deb
    logic [C_CNT_W-1:0] r_cnt;
    logic               r_f;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_cnt <= '0;
        r_f   <= 1'b1;
      end else if (w_raw[j] == r_f) begin
        r_cnt <= '0;
      end else if (r_cnt == C_CNT_LAST) begin
        r_f   <= w_raw[j];
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    assign w_filt[j] = r_f;
  end

  logic [NUM_CH-1:0] r_q;
  logic [NUM_CH-1:0] r_q_bar;
  logic [NUM_CH-1:0] r_set_pulse;
  logic [NUM_CH-1:0] r_clr_pulse;
  logic [NUM_CH-1:0] w_q_next;

  // Priority: force_clr, then filtered reset, then filtered set, else hold.
  always_comb begin
    w_q_next = '0;
    if (!bus.force_clr) begin
      w_q_next = w_r_filt & (~w_s_filt | r_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q         <= '0;
      r_q_bar     <= '1;
      r_set_pulse <= '0;
      r_clr_pulse <= '0;
    end else begin
      r_q         <= w_q_next;
      r_q_bar     <= ~w_q_next;
      r_set_pulse <= w_q_next & ~r_q;
      r_clr_pulse <= ~w_q_next & r_q;
    end
  end

  assign bus.q         = r_q;
  assign bus.q_bar     = r_q_bar;
  assign bus.set_pulse = r_set_pulse;
  assign bus.clr_pulse = r_clr_pulse;

endmodule

`default_nettype wire

// File: tb/tb_sr_latch_bank.sv
// ------------------------------------------------------------------------
// tb_sr_latch_bank : randomized and directed checks against a window model
// Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module tb_sr_latch_bank;

  localparam int NUM_CH = 4;
  localparam int DEB    = 4;
`ifdef SR_LATCH_BANK_SYNC_EN
  localparam int SYNC_STAGES = 2;
`else
  localparam int SYNC_STAGES = 0;
`endif
  localparam int LAT = DEB + 1 + SYNC_STAGES;
  localparam bit [DEB-1:0] ONES = '1;
  localparam bit [DEB-1:0] ZERO = '0;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sr_latch_bank_if #(.NUM_CH(NUM_CH)) bus ();

  sr_latch_bank #(
    .NUM_CH          (NUM_CH),
    .DEBOUNCE_CYCLES (DEB)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  // Reference model: an input is accepted once the last DEB delayed samples
  // all disagree with the current filtered level.
  bit [NUM_CH-1:0] m_q, m_sp, m_cp, m_s_filt, m_r_filt;
  bit [DEB-1:0]    m_s_win [NUM_CH];
  bit [DEB-1:0]    m_r_win [NUM_CH];
  bit [NUM_CH-1:0] m_s_dq [$];
  bit [NUM_CH-1:0] m_r_dq [$];

  always @(posedge clk) begin
    bit [NUM_CH-1:0] nq, in_s, in_r;
    if (!rst_n) begin
      m_q = '0; m_sp = '0; m_cp = '0;
      m_s_filt = '1; m_r_filt = '1;
      for (int i = 0; i < NUM_CH; i++) begin
        m_s_win[i] = ONES;
        m_r_win[i] = ONES;
      end
      m_s_dq.delete();
      m_r_dq.delete();
      for (int k = 0; k < SYNC_STAGES; k++) begin
        m_s_dq.push_back('1);
        m_r_dq.push_back('1);
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (bus.force_clr)     nq[i] = 1'b0;
        else if (!m_r_filt[i]) nq[i] = 1'b0;
        else if (!m_s_filt[i]) nq[i] = 1'b1;
        else                   nq[i] = m_q[i];
      end
      m_sp = nq & ~m_q;
      m_cp = ~nq & m_q;
      m_q  = nq;
      m_s_dq.push_back(bus.s_n);
      m_r_dq.push_back(bus.r_n);
      in_s = m_s_dq.pop_front();
      in_r = m_r_dq.pop_front();
      for (int i = 0; i < NUM_CH; i++) begin
        m_s_win[i] = DEB'({m_s_win[i], in_s[i]});
        if (m_s_win[i] == (m_s_filt[i] ? ZERO : ONES)) begin
          m_s_filt[i] = ~m_s_filt[i];
          m_s_win[i]  = m_s_filt[i] ? ONES : ZERO;
        end
        m_r_win[i] = DEB'({m_r_win[i], in_r[i]});
        if (m_r_win[i] == (m_r_filt[i] ? ZERO : ONES)) begin
          m_r_filt[i] = ~m_r_filt[i];
          m_r_win[i]  = m_r_filt[i] ? ONES : ZERO;
        end
      end
    end
  end

  always @(negedge clk) begin
    bit [NUM_CH-1:0] m_qb;
    if (chk_en) begin
      m_qb = ~m_q;
      check("q",         bus.q,         m_q);
      check("q_bar",     bus.q_bar,     m_qb);
      check("set_pulse", bus.set_pulse, m_sp);
      check("clr_pulse", bus.clr_pulse, m_cp);
    end
  end

  // Edges until q[ch] reaches val, bounded; 99 means it never did.
  task automatic wait_q(input int ch, input bit val, output int n);
    n = 99;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.q[ch] === val) begin
        n = k;
        break;
      end
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    bus.s_n = '0;
    bus.r_n = '1;
    bus.force_clr = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_q",   bus.q,         4'h0);
    check("rst_qb",  bus.q_bar,     4'hf);
    check("rst_sp",  bus.set_pulse, 4'h0);
    check("rst_cp",  bus.clr_pulse, 4'h0);

    bus.s_n = '1;
    rst_n   = 1'b1;
    repeat (10) @(negedge clk);
    bus.s_n[1] = 1'b0;
    wait_q(1, 1'b1, n);
    check("lat_set1",  n,             LAT);
    check("set1_q",    bus.q,         4'b0010);
    check("set1_sp",   bus.set_pulse, 4'b0010);
    @(negedge clk);
    check("set1_once", bus.set_pulse, 4'b0000);

    bus.s_n[2] = 1'b0;
    repeat (3) @(negedge clk);
    bus.s_n[2] = 1'b1;
    repeat (15) @(negedge clk);
    check("glitch3_q", bus.q, 4'b0010);

    n = 99;
    bus.s_n[2] = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == DEB) bus.s_n[2] = 1'b1;
      if (bus.q[2]) begin
        n = k;
        break;
      end
    end
    check("lat_glitch4", n, LAT);
    check("glitch4_q",   bus.q, 4'b0110);

    bus.s_n[0] = 1'b0;
    bus.r_n[0] = 1'b0;
    repeat (20) @(negedge clk);
    check("sr_both_q", bus.q, 4'b0110);
    bus.r_n[0] = 1'b1;
    wait_q(0, 1'b1, n);
    check("lat_rrel", n, LAT);
    check("rrel_sp",  bus.set_pulse, 4'b0001);

    bus.r_n[2] = 1'b0;
    bus.s_n[3] = 1'b0;
    repeat (20) @(negedge clk);
    bus.r_n[2] = 1'b1;
    bus.s_n    = '1;
    repeat (20) @(negedge clk);
    check("pre_force_q", bus.q, 4'b1011);

    bus.force_clr = 1'b1;
    @(negedge clk);
    bus.force_clr = 1'b0;
    check("force_q",  bus.q,         4'b0000);
    check("force_cp", bus.clr_pulse, 4'b1011);
    check("force_sp", bus.set_pulse, 4'b0000);
    repeat (3) @(negedge clk);
    bus.force_clr = 1'b1;
    @(negedge clk);
    bus.force_clr = 1'b0;
    check("force2_cp", bus.clr_pulse, 4'b0000);
    check("force2_q",  bus.q,         4'b0000);

    bus.s_n[3] = 1'b0;
    repeat (LAT - 2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_q", bus.q, 4'b0000);
    wait_q(3, 1'b1, n);
    check("lat_midrst", n, LAT);
    bus.s_n = '1;
    repeat (10) @(negedge clk);

    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(7) == 0) bus.s_n ^= 4'(1 << $urandom_range(NUM_CH - 1));
      if ($urandom_range(9) == 0) bus.r_n ^= 4'(1 << $urandom_range(NUM_CH - 1));
      bus.force_clr = ($urandom_range(24) == 0);
      rst_n         = ($urandom_range(199) != 0);
      @(negedge clk);
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
